// File: rtl/parity_frame_tx_pkg.sv
// =====================================================================
// Module   : parity_frame_tx_pkg
// Brief    : Shared state encodings and line constants for the framer.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

package parity_frame_tx_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_STOP   = 3'd4;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL = 1'b1;

    // Total clocks from first start-bit cycle to last stop-bit cycle.
    function automatic int frame_cycles(input int data_w, input int bit_cyc);
        return (data_w + 3) * bit_cyc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/parity_frame_tx_if.sv
// =====================================================================
// Module   : parity_frame_tx_if
// Brief    : Parallel word valid/ready handshake into the framer.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

interface parity_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

`default_nettype wire

// File: rtl/parity_frame_tx_acc.sv
// =====================================================================
// Module   : parity_acc
// Brief    : Serial XOR accumulator; clear wins over enable.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module parity_acc
    import parity_frame_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = 1'b0;
        end else if (en) begin
            acc_d = acc_q ^ bit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

`default_nettype wire

// File: rtl/parity_frame_tx.sv
// =====================================================================
// Module   : parity_frame_tx
// Brief    : Frames a parallel word as start/data(LSB first)/parity/stop.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module parity_frame_tx
    import parity_frame_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int BIT_CYC = 1,
    parameter int ODD     = 0
) (
    input  logic              clk,
    input  logic              rst,
    parity_frame_tx_if.slave  in_if,
    output logic              ser_out,
    output logic              busy,
    output logic              done,
    output logic              parity_out
);

    localparam int CNT_W = $clog2(BIT_CYC) + 1;
    localparam int IDX_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic ODD_BIT = (ODD != 0);

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]   shreg_q,   shreg_d;
    logic                ser_q,     ser_d;
    logic                parity_q,  parity_d;
    logic                done_q,    done_d;

    logic w_handshake;
    logic w_bit_last;
    logic w_data_last;
    logic w_parity;
    logic w_acc;
    logic w_acc_clr;
    logic w_acc_en;

    assign w_handshake = in_if.in_valid && (state_q == S_IDLE);
    assign w_bit_last  = (cnt_q == CNT_LAST);
    assign w_data_last = (bit_idx_q == IDX_LAST);
    // The last data bit enters the accumulator on the same edge that enters PARITY.
    assign w_parity    = w_acc ^ shreg_q[0] ^ ODD_BIT;

    parity_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_acc_clr),
        .en     (w_acc_en),
        .bit_in (shreg_q[0]),
        .acc    (w_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            ser_q     <= IDLE_LEVEL;
            parity_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            ser_q     <= ser_d;
            parity_q  <= parity_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_handshake) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_bit_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_last && w_data_last) begin
                    state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_bit_last) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        w_acc_clr = 1'b0;
        w_acc_en  = 1'b0;

        if ((state_q == S_IDLE) || w_bit_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_handshake) begin
                    shreg_d   = in_if.in_data;
                    bit_idx_d = '0;
                    w_acc_clr = 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_last) begin
                    w_acc_en = 1'b1;
                    shreg_d  = shreg_q >> 1;
                    if (w_data_last) begin
                        bit_idx_d = '0;
                        parity_d  = w_parity;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_last) begin
                    done_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // The line is registered, so it is driven from the state being entered.
        case (state_d)
            S_START:  ser_d = START_LEVEL;
            S_DATA:   ser_d = shreg_d[0];
            S_PARITY: ser_d = parity_d;
            S_STOP:   ser_d = STOP_LEVEL;
            default:  ser_d = IDLE_LEVEL;
        endcase
    end

    assign in_if.in_ready = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign ser_out        = ser_q;
    assign done           = done_q;
    assign parity_out     = parity_q;

endmodule

`default_nettype wire
